// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART receiver state encoding and constants
package uart_pkg;

  // Receiver frame states, fixed 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_DONE   = 3'd5
  } uart_rx_state_e;

  // Legal oversampling ratios
  localparam int PRESCALE_8  = 8;
  localparam int PRESCALE_16 = 16;
  localparam int PRESCALE_32 = 32;

  // Default number of data bits per frame
  localparam int DATA_WIDTH_DEF = 8;

endpackage

// File: rtl/edge_bit_counter.sv
// rtl/edge_bit_counter.sv - oversample edge counter and frame bit counter
module edge_bit_counter #(
  parameter int prescale_width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      clear,
  input  logic                      enable,
  input  logic [prescale_width-1:0] prescale,
  output logic [prescale_width-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      wrap
);

  // Last oversample of the current bit
  assign wrap = enable && (edge_cnt == (prescale - prescale_width'(1)));

  // Edge index within a bit, bit index advancing on each wrap; clear wins
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (wrap) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else if (enable) begin
      edge_cnt <= edge_cnt + prescale_width'(1);
    end
  end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver frame controller
module uart_rx_fsm
  import uart_pkg::*;
#(
  parameter int data_width     = DATA_WIDTH_DEF,
  parameter int prescale_width = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [prescale_width-1:0] Prescale,
  input  logic                      par_err,
  input  logic                      strt_glitch,
  input  logic                      stp_err,
  output logic [prescale_width-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      deser_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      data_valid
);

  uart_rx_state_e            state, next_state;
  logic [prescale_width-1:0] prescale_q;
  logic                      par_en_q;
  logic                      err_flag;
  logic                      cnt_en, cnt_clr, wrap;
  logic [prescale_width-1:0] samp_edge;
  logic                      in_window;

  // Counters run only while a bit is on the line; leaving for IDLE zeroes them
  assign cnt_en  = (state == ST_START) || (state == ST_DATA) ||
                   (state == ST_PARITY) || (state == ST_STOP);
  assign cnt_clr = (next_state == ST_IDLE);

  // The sampled bit is settled two edges after mid-bit
  assign samp_edge = (prescale_q >> 1) + prescale_width'(2);
  assign in_window = (edge_cnt >= samp_edge);

  edge_bit_counter #(
    .prescale_width(prescale_width)
  ) u_counter (
    .CLK     (CLK),
    .RST     (RST),
    .clear   (cnt_clr),
    .enable  (cnt_en),
    .prescale(prescale_q),
    .edge_cnt(edge_cnt),
    .bit_cnt (bit_cnt),
    .wrap    (wrap)
  );

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_IDLE;
    else      state <= next_state;
  end

  // Frame configuration is frozen once a start edge is seen
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
    end else if (state == ST_IDLE) begin
      prescale_q <= Prescale;
      par_en_q   <= PAR_EN;
    end
  end

  // Parity result is picked up on the first edge of the stop bit
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      err_flag <= 1'b0;
    end else if (state == ST_DONE) begin
      err_flag <= 1'b0;
    end else if ((state == ST_STOP) && (edge_cnt == '0) && par_en_q && par_err) begin
      err_flag <= 1'b1;
    end
  end

  // Next-state sequencing and checker/sampler enables
  always_comb begin
    next_state  = state;
    dat_samp_en = 1'b0;
    deser_en    = 1'b0;
    strt_chk_en = 1'b0;
    par_chk_en  = 1'b0;
    stp_chk_en  = 1'b0;
    data_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!RX_IN) next_state = ST_START;
      end
      ST_START: begin
        dat_samp_en = 1'b1;
        strt_chk_en = in_window;
        if (wrap) next_state = ST_DATA;
      end
      ST_DATA: begin
        dat_samp_en = 1'b1;
        deser_en    = (edge_cnt == samp_edge);
        if ((bit_cnt == 4'd1) && (edge_cnt == '0) && strt_glitch) begin
          next_state = ST_IDLE;
          deser_en   = 1'b0;
        end else if (wrap && (bit_cnt == 4'(data_width))) begin
          next_state = par_en_q ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        dat_samp_en = 1'b1;
        par_chk_en  = in_window;
        if (wrap) next_state = ST_STOP;
      end
      ST_STOP: begin
        dat_samp_en = 1'b1;
        stp_chk_en  = in_window;
        if (wrap) next_state = ST_DONE;
      end
      ST_DONE: begin
        data_valid = ~err_flag & ~stp_err;
        next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - randomized scoreboard bench for uart_rx_fsm
`timescale 1ns/1ps
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       par_err, strt_glitch, stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;

  uart_rx_fsm dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .Prescale   (Prescale),
    .par_err    (par_err),
    .strt_glitch(strt_glitch),
    .stp_err    (stp_err),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .dat_samp_en(dat_samp_en),
    .deser_en   (deser_en),
    .strt_chk_en(strt_chk_en),
    .par_chk_en (par_chk_en),
    .stp_chk_en (stp_chk_en),
    .data_valid (data_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         ready = 0;
  int         frame_p = 8;
  int         deser_seen = 0;
  logic       sampled_bit;
  logic [7:0] pdata;
  logic [15:0] outs;

  assign outs = {edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                 par_chk_en, stp_chk_en, data_valid};

  always @(posedge CLK) cyc <= cyc + 1;

  // Neighbouring blocks: mid-bit sampler, deserializer and registered checkers
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sampled_bit <= 1'b1;
      pdata       <= 8'h00;
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      if (dat_samp_en && (int'(edge_cnt) == frame_p / 2)) sampled_bit <= RX_IN;
      if (deser_en)    pdata       <= {sampled_bit, pdata[7:1]};
      if (strt_chk_en) strt_glitch <= sampled_bit;
      if (par_chk_en)  par_err     <= sampled_bit ^ (^pdata);
      if (stp_chk_en)  stp_err     <= ~sampled_bit;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp = n_cmp + 1;
    if (act !== req) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard monitor plus enable-window checks
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (data_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_data_valid", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("frame_data", 32'(pdata), 32'(mon_e.data));
          chk("frame_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
      if (strt_chk_en || par_chk_en || stp_chk_en)
        chk("chk_en_window", 32'((int'(edge_cnt) >= frame_p / 2 + 2) &&
                                 (int'(edge_cnt) <= frame_p - 1)), 32'd1);
      if (deser_en) begin
        deser_seen = deser_seen + 1;
        chk("deser_edge", 32'(edge_cnt), 32'(frame_p / 2 + 2));
      end
    end
  end

  function automatic int rand_p();
    return 8 << ($urandom % 3);
  endfunction

  task automatic hold(input logic v, input int n);
    RX_IN = v;
    repeat (n) @(negedge CLK);
  endtask

  // Earliest legal start is the DONE cycle of the previous frame
  task automatic wait_ready();
    int guard = 0;
    while ((cyc + 1 < ready - 1) && (guard < 2000)) begin
      @(negedge CLK);
      guard++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic bad_par, input logic bad_stop, input int gap);
    int nb, det;
    repeat (gap) @(negedge CLK);
    wait_ready();
    Prescale = 6'(p);
    PAR_EN   = pe;
    frame_p  = p;
    nb  = 10 + int'(pe);
    det = (cyc + 1 > ready) ? cyc + 1 : ready;
    if (!bad_stop && !(pe && bad_par)) exp_q.push_back('{d, det + nb * p});
    ready = det + nb * p + 2;
    hold(1'b0, 3);
    Prescale = 6'(rand_p());
    PAR_EN   = 1'($urandom);
    repeat (p - 3) @(negedge CLK);
    for (int i = 0; i < 8; i++) hold(d[i], p);
    if (pe) hold((^d) ^ bad_par, p);
    hold(~bad_stop, p);
    RX_IN = 1'b1;
  endtask

  task automatic send_glitch(input int p);
    int det, d0;
    wait_ready();
    Prescale = 6'(p);
    PAR_EN   = 1'($urandom);
    frame_p  = p;
    det   = (cyc + 1 > ready) ? cyc + 1 : ready;
    ready = det + p + 2;
    d0    = deser_seen;
    hold(1'b0, 3);
    RX_IN = 1'b1;
    while (cyc < det + p) @(negedge CLK);
    chk("abort_bit_cnt", 32'(bit_cnt), 32'd1);
    chk("abort_edge_cnt", 32'(edge_cnt), 32'd0);
    @(negedge CLK);
    chk("abort_idle_outputs", 32'(outs), 32'd0);
    repeat (p) @(negedge CLK);
    chk("abort_no_deser", 32'(deser_seen - d0), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RST = 1'b0;
    RX_IN = 1'b1;
    PAR_EN = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", 32'(outs), 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    chk("idle_outputs", 32'(outs), 32'd0);

    send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b0, 2);
    send_frame(8'hA5, 8, 1'b1, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 16, 1'b0, 1'b0, 1'b1, 0);
    send_glitch(16);

    // Reset in the middle of data bit 4
    repeat (3) @(negedge CLK);
    Prescale = 6'd16;
    PAR_EN   = 1'b0;
    frame_p  = 16;
    hold(1'b0, 16);
    for (int i = 0; i < 3; i++) hold(1'b1, 16);
    repeat (5) @(negedge CLK);
    chk("pre_reset_bit_cnt", 32'(bit_cnt), 32'd4);
    #2 RST = 1'b0;
    #1 chk("async_reset_outputs", 32'(outs), 32'd0);
    RX_IN = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    ready = cyc + 1;
    @(negedge CLK);
    chk("post_reset_idle", 32'(outs), 32'd0);
    send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, 3);

    // Back-to-back: next start bit first seen on the DONE cycle
    send_frame(8'h5A, 16, 1'b1, 1'b0, 1'b0, 0);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h81, 32, 1'b1, 1'b0, 1'b0, 0);

    for (int i = 0; i < 28; i++) begin
      if ($urandom % 10 == 0) begin
        send_glitch(rand_p());
      end else begin
        send_frame(8'($urandom), rand_p(), 1'($urandom), ($urandom % 4 == 0),
                   ($urandom % 6 == 0), int'($urandom % 3));
      end
    end

    guard = 0;
    while ((cyc < ready + 2) && (guard < 2000)) begin
      @(negedge CLK);
      guard++;
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
